// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end: RV32I major opcodes, the decoded
// bundle handed from decode to execute, and an opcode classifier that says
// which register operands an instruction reads and writes.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // Register usage of an opcode. An unknown opcode comes back all-zero, so it
  // reads nothing, writes nothing and is flagged illegal.
  typedef struct packed {
    logic legal;
    logic use_rs1;
    logic use_rs2;
    logic writes_rd;
  } op_class_t;

  // Decoded bundle. rs1/rs2/rd are already zeroed when the format has no such
  // operand, so consumers never see immediate bits masquerading as registers.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [WORD_W-1:0] imm;
    logic              illegal;
  } decoded_t;

  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t c;
    c = '0;
    case (opcode)
      OP: begin
        c.legal = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.writes_rd = 1'b1;
      end
      STORE, BRANCH: begin
        c.legal = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
      end
      OP_IMM, LOAD, JALR: begin
        c.legal = 1'b1; c.use_rs1 = 1'b1; c.writes_rd = 1'b1;
      end
      LUI, AUIPC, JAL: begin
        c.legal = 1'b1; c.writes_rd = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage : cpu_pkg

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational RV32I immediate generator. Selects the I/S/B/U/J layout from
// the opcode and sign-extends to the word width. R-type and unknown opcodes
// yield zero.
// Ports:
//   instr_i  in  32  instruction word
//   imm_o    out 32  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0]       instr_i,
  output logic [WORD_W-1:0] imm_o
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path assigned,
    // so this stays pure combinational logic instead of inferring a latch.
    imm_o = '0;
    case (instr_i[6:0])
      OP_IMM, LOAD, JALR:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                 instr_i[30:25], instr_i[11:8], 1'b0};
      LUI, AUIPC:
        imm_o = {instr_i[31:12], 12'b0};
      JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                 instr_i[20], instr_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule : imm_gen

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode
// Instruction decode stage. Accepts fetched instructions on a valid/ready
// handshake, splits them into RV32I fields plus a sign-extended immediate and
// holds the result in a single output register. Drives the register-file read
// addresses so operand data lines up with the bundle presented downstream.
//
// Build option DECODE_SCOREBOARD_EN: when defined, a 32-entry busy bitmap
// stalls RAW and WAW hazards; bits are set on issue and cleared by writeback.
// When undefined there is no bitmap and wb_valid/wb_rd are ignored.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  fetch handshake; in_ready looks at in_instr
//   in_instr, in_pc    instruction word and its PC
//   out_valid/ready    bundle handshake towards execute
//   out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_imm, out_illegal
//                      registered bundle; out_rd is 0 for formats without rd
//   r_address1/2       register-file read addresses (0 for unused sources)
//   wb_valid, wb_rd    writeback clears the busy bit of wb_rd
// -----------------------------------------------------------------------------
module decode
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic [4:0]      r_address1,
  output logic [4:0]      r_address2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  // ---------------------------------------------------------------------------
  // Field extraction for the instruction currently offered by fetch
  // ---------------------------------------------------------------------------
  op_class_t         cls;
  logic [4:0]        rs1_eff, rs2_eff, rd_eff;
  logic [WORD_W-1:0] imm;
  logic              hazard;
  logic              fire;
  logic              hold;

  assign cls     = classify(in_instr[6:0]);
  assign rs1_eff = cls.use_rs1   ? in_instr[19:15] : 5'd0;
  assign rs2_eff = cls.use_rs2   ? in_instr[24:20] : 5'd0;
  assign rd_eff  = cls.writes_rd ? in_instr[11:7]  : 5'd0;

  imm_gen u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (imm)
  );

  // ---------------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------------
`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic        src1_hit, src2_hit, dst_hit;

  // Zeroed operand fields double as "not used", and x0 is never busy-checked.
  // Illegal opcodes have every operand zeroed, so they never stall.
  assign src1_hit = (rs1_eff != 5'd0) && busy_q[rs1_eff];
  assign src2_hit = (rs2_eff != 5'd0) && busy_q[rs2_eff];
  assign dst_hit  = (rd_eff  != 5'd0) && busy_q[rd_eff];
  assign hazard   = src1_hit || src2_hit || dst_hit;

  // The WAW stall guarantees a set and a clear never target the same bit in
  // one cycle, so their order here does not matter.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (fire && (rd_eff != 5'd0)) busy_d[rd_eff] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd};
  assign hazard    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and output pipeline register
  // ---------------------------------------------------------------------------
  logic     out_valid_q;
  decoded_t bundle_q, bundle_d;

  assign in_ready = !rst && (!out_valid_q || out_ready) && !hazard;
  assign fire     = in_valid && in_ready;
  assign hold     = out_valid_q && !out_ready;

  always_comb begin
    bundle_d         = '0;
    bundle_d.pc      = in_pc;
    bundle_d.opcode  = in_instr[6:0];
    bundle_d.funct3  = in_instr[14:12];
    bundle_d.funct7  = in_instr[31:25];
    bundle_d.rd      = rd_eff;
    bundle_d.rs1     = rs1_eff;
    bundle_d.rs2     = rs2_eff;
    bundle_d.imm     = imm;
    bundle_d.illegal = !cls.legal;
  end

  // NOTE: the payload is reset along with the valid bit because every bundle
  // output has to read zero out of reset, not just out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (fire) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      out_valid_q <= 1'b1;
      bundle_q    <= bundle_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file read addresses. While the bundle is stalled downstream the
  // addresses stay on its sources so the operand data does not change under
  // it; otherwise they look ahead at the incoming instruction so its data is
  // ready in the cycle it is presented.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_address1 = 5'd0;
    r_address2 = 5'd0;
    if (!rst) begin
      if (hold) begin
        r_address1 = bundle_q.rs1;
        r_address2 = bundle_q.rs2;
      end else begin
        r_address1 = rs1_eff;
        r_address2 = rs2_eff;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = bundle_q.pc;
  assign out_opcode  = bundle_q.opcode;
  assign out_funct3  = bundle_q.funct3;
  assign out_funct7  = bundle_q.funct7;
  assign out_rd      = bundle_q.rd;
  assign out_imm     = bundle_q.imm;
  assign out_illegal = bundle_q.illegal;

endmodule : decode

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode
// Directed bench for decode. Each issued instruction pushes its hand-computed
// bundle into a queue; a monitor pops and compares whenever the DUT hands a
// bundle to execute. Handshake, stall and address behaviour is checked inline.
// Hazard expectations follow DECODE_SCOREBOARD_EN.
// -----------------------------------------------------------------------------
module tb_decode;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [4:0]  r_address1;
  logic [4:0]  r_address2;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  decode #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .r_address1  (r_address1),
    .r_address2  (r_address2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] opcode,
                              input logic [2:0] funct3, input logic [6:0] funct7,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic illegal);
    exp_t e;
    e.pc = pc; e.opcode = opcode; e.funct3 = funct3; e.funct7 = funct7;
    e.rd = rd; e.imm = imm; e.illegal = illegal;
    return e;
  endfunction

  // Monitor: sample just before the rising edge, pop on a completed handoff.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_bundle: got pc 0x%08h, expected no bundle", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("bundle_pc",      out_pc,              e.pc);
          check("bundle_opcode",  32'(out_opcode),     32'(e.opcode));
          check("bundle_funct3",  32'(out_funct3),     32'(e.funct3));
          check("bundle_funct7",  32'(out_funct7),     32'(e.funct7));
          check("bundle_rd",      32'(out_rd),         32'(e.rd));
          check("bundle_imm",     out_imm,             e.imm);
          check("bundle_illegal", 32'(out_illegal),    32'(e.illegal));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 50000", $time);
    $fatal(1);
  end

  // Offer one instruction, expect it to be accepted without stalling, check
  // the look-ahead read addresses, and queue its expected bundle.
  task automatic send(input string name, input logic [31:0] instr, input exp_t e,
                      input logic [4:0] ra1, input logic [4:0] ra2);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = e.pc;
    #1;
    check({name, "_ready"},  32'(in_ready),   32'd1);
    check({name, "_raddr1"}, 32'(r_address1), 32'(ra1));
    check({name, "_raddr2"}, 32'(r_address2), 32'(ra2));
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (in_ready === 1'b1) exp_q.push_back(e);
    else $display("FAIL %s_timeout: got in_ready 0 after %0d cycles, expected 1", name, waited);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] rd);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rd    = rd;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  localparam logic [31:0] ADDI_X1   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADD_X2    = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] ADDI_X6   = 32'h0012_8313; // addi x6,x5,1
  localparam logic [31:0] SW_X3     = 32'h0032_2423; // sw   x3,8(x4)
  localparam logic [31:0] ADDI_X9   = 32'h0004_0493; // addi x9,x8,0
  localparam logic [31:0] ILLEGAL   = 32'h0000_007F;
  localparam logic [31:0] LUI_X0    = 32'h1234_5037; // lui  x0,0x12345
  localparam logic [31:0] ADD_X7    = 32'h0000_03B3; // add  x7,x0,x0
  localparam logic [31:0] BNE_NEG   = 32'hFE62_98E3; // bne  x5,x6,-16
  localparam logic [31:0] JAL_NEG   = 32'h801F_F06F; // jal  x0,-2048

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = ADD_X2;
    in_pc     = 32'h0;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;

    // Reset state: outputs zero, not ready, addresses forced to zero.
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),    32'd0);
    check("rst_raddr1",    32'(r_address1),  32'd0);
    check("rst_raddr2",    32'(r_address2),  32'd0);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_out_pc",    out_pc,           32'd0);
    check("rst_out_imm",   out_imm,          32'd0);
    check("rst_out_rd",    32'(out_rd),      32'd0);
    check("rst_out_op",    32'(out_opcode),  32'd0);
    check("rst_illegal",   32'(out_illegal), 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    send("addi_x1", ADDI_X1, mk(32'h100, 7'h13, 3'd0, 7'h00, 5'd1, 32'd5, 1'b0), 5'd0, 5'd0);

    // add x2,x1,x1 right behind it: RAW stall until the cycle after writeback.
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ADD_X2;
    in_pc    = 32'h104;
    #1;
    check("raw_in_ready", 32'(in_ready),   SB_EN ? 32'd0 : 32'd1);
    check("raw_raddr1",   32'(r_address1), 32'd1);
    check("raw_raddr2",   32'(r_address2), 32'd1);
    if (in_ready !== 1'b1) begin
      repeat (2) begin
        @(negedge clk);
        #1;
        check("raw_hold", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      wb_valid = 1'b1;
      wb_rd    = 5'd1;
      #1;
      check("raw_wb_same_cycle", 32'(in_ready), 32'd0);
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      check("raw_wb_next_cycle", 32'(in_ready),   32'd1);
      check("raw_issue_raddr1",  32'(r_address1), 32'd1);
      check("raw_issue_raddr2",  32'(r_address2), 32'd1);
    end
    exp_q.push_back(mk(32'h104, 7'h33, 3'd0, 7'h00, 5'd2, 32'd0, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wb_pulse(5'd2);

    // Backpressure: hold addi x6,x5,1 for three cycles with sw waiting.
    send("addi_x6", ADDI_X6, mk(32'h108, 7'h13, 3'd0, 7'h00, 5'd6, 32'd1, 1'b0), 5'd5, 5'd0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = SW_X3;
    in_pc     = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_out_valid", 32'(out_valid),  32'd1);
      check("hold_out_pc",    out_pc,          32'h108);
      check("hold_out_imm",   out_imm,         32'd1);
      check("hold_out_rd",    32'(out_rd),     32'd6);
      check("hold_raddr1",    32'(r_address1), 32'd5);
      check("hold_raddr2",    32'(r_address2), 32'd0);
      check("hold_in_ready",  32'(in_ready),   32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wb_pulse(5'd6);

    // Store has no rd; a following reader of x8 must not stall.
    send("sw",      SW_X3,   mk(32'h10C, 7'h23, 3'd2, 7'h00, 5'd0, 32'd8, 1'b0), 5'd4, 5'd3);
    send("addi_x9", ADDI_X9, mk(32'h110, 7'h13, 3'd0, 7'h00, 5'd9, 32'd0, 1'b0), 5'd8, 5'd0);
    send("illegal", ILLEGAL, mk(32'h114, 7'h7F, 3'd0, 7'h00, 5'd0, 32'd0, 1'b1), 5'd0, 5'd0);
    send("lui_x0",  LUI_X0,  mk(32'h118, 7'h37, 3'd5, 7'h09, 5'd0, 32'h1234_5000, 1'b0), 5'd0, 5'd0);
    send("add_x7",  ADD_X7,  mk(32'h11C, 7'h33, 3'd0, 7'h00, 5'd7, 32'd0, 1'b0), 5'd0, 5'd0);
    send("bne",     BNE_NEG, mk(32'h120, 7'h63, 3'd1, 7'h7F, 5'd0, 32'hFFFF_FFF0, 1'b0), 5'd5, 5'd6);
    send("jal",     JAL_NEG, mk(32'h124, 7'h6F, 3'd7, 7'h40, 5'd0, 32'hFFFF_F800, 1'b0), 5'd0, 5'd0);

    // Reset in the middle of a stall with x1 busy and a bundle held.
    send("addi_x1b", ADDI_X1, mk(32'h200, 7'h13, 3'd0, 7'h00, 5'd1, 32'd5, 1'b0), 5'd0, 5'd0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = ADD_X2;
    in_pc     = 32'h204;
    #1;
    check("stall_before_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready),   32'd0);
    check("midrst_raddr1",   32'(r_address1), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_out_pc",    out_pc,          32'd0);
    check("post_rst_out_rd",    32'(out_rd),     32'd0);
    send("add_x2b", ADD_X2, mk(32'h204, 7'h33, 3'd0, 7'h00, 5'd2, 32'd0, 1'b0), 5'd1, 5'd1);

    repeat (3) @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_decode
